// File: rtl/rx_fcs_strip.sv
// rx_fcs_strip
//   Receive-path byte-stream stage that strips the trailing FCS_BYTES bytes
//   (the Ethernet FCS) from every frame and flags bad frames on the final
//   output beat. A FCS_BYTES-deep window delays the stream so a byte is
//   released only once it is known not to belong to the FCS.
//
//   Optional feature macro: RX_FCS_STRIP_CRC_CHECK_EN
//     defined   -> CRC-32 is checked over the whole frame (FCS included) and
//                  a residue mismatch raises err_out on the last beat.
//     undefined -> no CRC logic; err_out reports runt frames only.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   data_in    in   [7:0] input byte
//   valid_in   in   input byte strobe (no backpressure)
//   last_in    in   final byte of frame, qualified by valid_in
//   data_out   out  [7:0] payload byte (registered)
//   valid_out  out  single-cycle beat strobe
//   last_out   out  final beat of frame, qualified by valid_out
//   err_out    out  frame error, meaningful with valid_out && last_out
module rx_fcs_strip #(
  parameter int FCS_BYTES = 4,
  parameter int MIN_FRAME = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       last_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       last_out,
  output logic       err_out
);

  localparam int              WC_W    = $clog2(FCS_BYTES + 1);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(FCS_BYTES);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t               state_q;
  logic [WC_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           win_q [FCS_BYTES];
  logic                 runt;
  logic                 crc_bad;

  // Count including the byte being accepted now; sticks at all-ones.
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign wcnt_d = (wcnt_q == WC_FULL) ? wcnt_q : wcnt_q + WC_W'(1);

  // A saturated count means the frame is certainly long enough.
  assign runt = !(&cnt_d) && (32'(cnt_d) < MIN_FRAME);

`ifdef RX_FCS_STRIP_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign crc_d   = crc32_byte(crc_q, data_in);
  // Running the CRC across a frame plus its own FCS leaves a fixed residue.
  assign crc_bad = (crc_d != 32'hDEBB20E3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc_q <= '1;
    else if (valid_in)
      crc_q <= last_in ? '1 : crc_d;
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Window contents carry no reset; only the fill count decides what is valid.
  // win_q[0] is the oldest byte once the window is full.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int i = 0; i < FCS_BYTES - 1; i++)
        win_q[i] <= win_q[i+1];
      win_q[FCS_BYTES-1] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      err_out   <= 1'b0;
      if (valid_in) begin
        if (state_q == STREAM) begin
          // Window full: the oldest byte is payload and leaves now.
          valid_out <= 1'b1;
          data_out  <= win_q[0];
          last_out  <= last_in;
          err_out   <= last_in && (runt || crc_bad);
        end else if (last_in) begin
          // Frame ended before any payload existed: emit an error marker.
          valid_out <= 1'b1;
          data_out  <= '0;
          last_out  <= 1'b1;
          err_out   <= 1'b1;
        end

        if (last_in) begin
          state_q <= IDLE;
          wcnt_q  <= '0;
          cnt_q   <= '0;
        end else begin
          wcnt_q  <= wcnt_d;
          cnt_q   <= cnt_d;
          state_q <= (wcnt_d == WC_FULL) ? STREAM : FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_fcs_strip.sv
// Testbench for rx_fcs_strip: table of frame cases plus hand-written
// sequences for the short-frame marker and mid-frame reset.
module tb_rx_fcs_strip;

  localparam int FCS = 4;

`ifdef RX_FCS_STRIP_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       last_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       last_out;
  logic       err_out;

  rx_fcs_strip #(.FCS_BYTES(FCS), .MIN_FRAME(64), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .last_in  (last_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .last_out (last_out),
    .err_out  (err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
    int         c;
  } beat_t;

  beat_t      beats[$];
  int         acc[$];
  logic [7:0] fr[$];
  logic [7:0] expq[$];

  // Input acceptance cycles (sampled at the edge the DUT uses).
  always @(posedge clk) if (valid_in && !rst) acc.push_back(cyc);
  // Output beats, sampled mid-cycle.
  always @(negedge clk) if (valid_out) beats.push_back('{data_out, last_out, err_out, cyc});

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Build a frame of len bytes: payload followed by a correct FCS
  // (LSB first), optionally with one payload bit flipped afterwards.
  task automatic build(input int len, input int seed, input int corrupt);
    logic [31:0] c;
    logic [7:0]  b;
    fr.delete();
    c = 32'hFFFFFFFF;
    if (len <= 4) begin
      for (int i = 0; i < len; i++) fr.push_back(8'(seed + i * 17));
    end else begin
      for (int i = 0; i < len - 4; i++) begin
        b = 8'(i * 7 + seed);
        fr.push_back(b);
        c = crc_upd(c, b);
      end
      c = ~c;
      for (int j = 0; j < 4; j++) fr.push_back(c[8*j +: 8]);
      if (corrupt >= 0) fr[corrupt] = fr[corrupt] ^ 8'h01;
    end
  endtask

  task automatic send(input int lo, input int hi, input bit gap);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      data_in  = fr[i];
      valid_in = 1'b1;
      last_in  = (i == fr.size() - 1);
      if (gap) begin
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      last_in  = 1'b0;
    end
  endtask

  task automatic clear_q();
    beats.delete();
    acc.delete();
  endtask

  // Compare the collected beats against the first np bytes of fr.
  task automatic check_frame(input string nm, input int np, input bit exp_err);
    int n, bad_d, bad_l, bad_t;
    chk({nm, "_beats"}, beats.size(), np);
    n = (beats.size() < np) ? beats.size() : np;
    bad_d = 0; bad_l = 0; bad_t = 0;
    for (int k = 0; k < n; k++) begin
      if (beats[k].d !== fr[k]) bad_d++;
      if (beats[k].l !== (k == np - 1)) bad_l++;
      if (k + FCS >= acc.size()) bad_t++;
      else if (beats[k].c != acc[k+FCS] + 1) bad_t++;
    end
    chk({nm, "_data"}, bad_d, 0);
    chk({nm, "_last"}, bad_l, 0);
    chk({nm, "_latency"}, bad_t, 0);
    chk({nm, "_err"}, (beats.size() > 0) ? int'(beats[beats.size()-1].e) : -1, int'(exp_err));
  endtask

  typedef struct {
    int len;
    bit gap;
    int corrupt;
    int seed;
    bit exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nb, bad_d, bad_l, bad_t;

    vecs[0] = '{64, 1'b0, -1, 3,  1'b0};   // clean frame right after reset test
    vecs[1] = '{64, 1'b0, 10, 3,  CRC_EN}; // corrupted payload byte 10
    vecs[2] = '{30, 1'b0, -1, 21, 1'b1};   // runt
    vecs[3] = '{64, 1'b1, -1, 3,  1'b0};   // gapped valid
    vecs[4] = '{63, 1'b0, -1, 40, 1'b1};   // one below minimum
    vecs[5] = '{65, 1'b0, -1, 77, 1'b0};   // one above minimum
    vecs[6] = '{5,  1'b0, -1, 90, 1'b1};   // smallest frame with payload

    rst = 1'b1; data_in = '0; valid_in = 1'b0; last_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({data_out, valid_out, last_out, err_out}), 0);
    rst = 1'b0;
    idle(2);

    // 3-byte frame followed immediately by a good 64-byte frame.
    clear_q();
    build(3, 8'h11, -1);
    send(0, 2, 1'b0);
    build(64, 5, -1);
    send(0, 63, 1'b0);
    idle(3);
    chk("mk_beats", beats.size(), 61);
    if (beats.size() > 0 && acc.size() > 2) begin
      chk("mk_marker", int'({beats[0].d, beats[0].l, beats[0].e}), 3);
      chk("mk_marker_time", beats[0].c, acc[2] + 1);
    end
    nb = (beats.size() > 61) ? 60 : beats.size() - 1;
    bad_d = 0; bad_l = 0; bad_t = 0;
    for (int k = 0; k < nb; k++) begin
      if (beats[k+1].d !== fr[k]) bad_d++;
      if (beats[k+1].l !== (k == 59)) bad_l++;
      if (3 + k + FCS >= acc.size()) bad_t++;
      else if (beats[k+1].c != acc[3+k+FCS] + 1) bad_t++;
    end
    chk("mk_next_data", bad_d, 0);
    chk("mk_next_last", bad_l, 0);
    chk("mk_next_latency", bad_t, 0);
    chk("mk_next_err", (beats.size() > 1) ? int'(beats[beats.size()-1].e) : -1, 0);

    // Reset after byte 20 of a 100-byte frame; bytes 21..99 follow release.
    clear_q();
    build(100, 9, -1);
    expq.delete();
    for (int k = 0; k <= 16; k++) expq.push_back(fr[k]);
    for (int k = 21; k <= 95; k++) expq.push_back(fr[k]);
    send(0, 20, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1; valid_in = 1'b0; last_in = 1'b0;
    #1;
    chk("rst_async", int'({data_out, valid_out, last_out, err_out}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", int'({data_out, valid_out, last_out, err_out}), 0);
    rst = 1'b0;
    send(21, 99, 1'b0);
    idle(3);
    chk("rst_beats", beats.size(), expq.size());
    nb = (beats.size() < expq.size()) ? beats.size() : expq.size();
    bad_d = 0; bad_l = 0;
    for (int k = 0; k < nb; k++) begin
      if (beats[k].d !== expq[k]) bad_d++;
      if (beats[k].l !== (k == expq.size() - 1)) bad_l++;
    end
    chk("rst_data", bad_d, 0);
    chk("rst_last", bad_l, 0);

    // Table-driven frame cases.
    for (int v = 0; v < 7; v++) begin
      clear_q();
      build(vecs[v].len, vecs[v].seed, vecs[v].corrupt);
      send(0, vecs[v].len - 1, vecs[v].gap);
      idle(3);
      check_frame($sformatf("vec%0d", v), vecs[v].len - FCS, vecs[v].exp_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
